bldc_commutator: RTL and testbench
==================================

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 The block SHALL have parameter PWM_W, default 8, PWM duty resolution in bits.
REQ-002 The block SHALL have parameter PWM_DIV, default 4, clk cycles per PWM counter step (>=1).
REQ-003 The block SHALL have parameter FILT_N, default 16, cycles a synchronised hall code must be stable before acceptance.
REQ-004 The block SHALL have parameter WIN_CYC, default 500000, clk cycles per speed-measurement window.
REQ-005 The block SHALL have parameter FORCE_CYC, default 250000, clk cycles per forced-commutation step.
REQ-006 The block SHALL have parameter DEAD_CYC, default 50, all-off clk cycles inserted on every commutation change.
REQ-007 The block SHALL have parameter CNT_W, default 12, width of the edge counter.
REQ-008 The block SHALL have port clk, input, 1 bit, the single clock; already decided.
REQ-009 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset; already decided.
REQ-010 The block SHALL have port enable, input, 1 bit, run request.
REQ-011 The block SHALL have port direction, input, 1 bit, 1=CW, 0=CCW.
REQ-012 The block SHALL have port hall, input, 3 bits, raw asynchronous hall sensors.
REQ-013 The block SHALL have port duty, input, PWM_W bits, requested duty.
REQ-014 The block SHALL have port hin, output, 3 bits, high-side drive [R,S,T], active-high.
REQ-015 The block SHALL have port lin_n, output, 3 bits, low-side drive [R,S,T], active-low.
REQ-016 The block SHALL have port edge_count, output, CNT_W bits, accepted hall edges in the last window.
REQ-017 The block SHALL have port edge_valid, output, 1 bit, one-cycle strobe when edge_count updates.
REQ-018 The block SHALL have port state_o, output, 2 bits, with encoding IDLE=0, FORCED=1, CLOSED=2, FAULT=3.
REQ-019 The block SHALL have port hall_fault, output, 1 bit, sticky invalid-hall flag.

Function
REQ-020 hall SHALL pass two flops then a stability filter, and the accepted code SHALL update only after FILT_N consecutive equal synchronised samples.
REQ-021 The commutation step for CW SHALL be derived from accepted hall as 1->4, 2->0, 3->5, 4->2, 5->3, 6->1.
REQ-022 The commutation step for CCW SHALL be derived from accepted hall as 1->1, 2->3, 3->2, 4->5, 5->0, 6->4.
REQ-023 The step-to-phase mapping SHALL be high/low on 0:R/S, 1:R/T, 2:S/T, 3:S/R, 4:T/R, 5:T/S, with the remaining phase having both switches off.
REQ-024 PWM SHALL gate only the low side, with lin_n[x] = NOT(low_on[x] AND pwm) and hin unaffected by PWM.
REQ-025 The PWM counter SHALL be free-running and PWM_W wide, advancing once per PWM_DIV clk, with pwm = (counter < duty), so duty=0 means always off and duty=2^PWM_W-1 gives off for exactly 1 count per period.
REQ-026 On any change of commanded step, hin SHALL be 0 and lin_n SHALL be 3'b111 for DEAD_CYC cycles before the new step is driven, and a step change during dead time SHALL restart the dead timer.
REQ-027 In IDLE, hin SHALL be 0 and lin_n SHALL be 3'b111, and IDLE SHALL go to FORCED when enable=1.
REQ-028 In FORCED, step SHALL advance by +1 mod 6 (CW) or -1 mod 6 (CCW) every FORCE_CYC cycles, and FORCED SHALL go to CLOSED at a window end with edge_count>=2.
REQ-029 In CLOSED, step SHALL follow the hall table, and CLOSED SHALL go to FORCED at a window end with edge_count=0.
REQ-030 Any state except FAULT SHALL go to IDLE on enable=0 within 1 cycle, with outputs off that cycle.
REQ-031 An accepted code of 000 or 111 SHALL set hall_fault and enter FAULT, where outputs are off.
REQ-032 FAULT SHALL exit to IDLE only when enable=0, which also clears hall_fault.
REQ-033 The speed counter SHALL count accepted-code changes, saturating at 2^CNT_W-1.
REQ-034 At each WIN_CYC boundary, the speed counter value SHALL be copied to edge_count, edge_valid SHALL pulse, and the counter SHALL restart at 0, or at 1 if an edge coincides with the boundary.
REQ-035 A direction change while running SHALL take effect on the next step computation, with dead time applied per REQ-026.

Reset
REQ-036 While rst_n=0, state_o SHALL be IDLE, hin SHALL be 0, lin_n SHALL be 3'b111, edge_count SHALL be 0, edge_valid SHALL be 0, hall_fault SHALL be 0, and all counters, filters and the step SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL force the outputs off immediately (asynchronously).
REQ-038 Release of rst_n SHALL be synchronised internally, and the first active cycle SHALL behave as IDLE.

Verification
REQ-039 Directed test, reset release: enable=0, hall=3'b101 -> hin=0, lin_n=3'b111, state_o=0 for 100 cycles.
REQ-040 Directed test, closed-loop CW: enable=1, direction=1, hall sequence 1,3,2,6,4,5 stepped every 20000 cycles, duty=128 -> state_o reaches 2, step order 4,5,0,1,2,3, DEAD_CYC off-gap measured on every change, low-side PWM at 50% (128 of 256 counts).
REQ-041 Directed test, glitch rejection: hall pulse lasting FILT_N-1 cycles -> no step change and no count; pulse lasting FILT_N+2 cycles -> exactly one edge counted.
REQ-042 Directed test, stall: hall held constant in CLOSED for one full window -> edge_count=0, state_o returns to 1, forced step period equals FORCE_CYC.
REQ-043 Directed test, hall fault: hall=3'b111 held -> hall_fault=1, state_o=3, outputs off, persisting with enable=1; enable=0 -> hall_fault=0, state_o=0.
REQ-044 Directed test, duty boundaries: duty=0 -> lin_n constantly 3'b111; duty=255 -> active low leg off for exactly 1 of 256 counts.

Source files
------------

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: filtered hall decode, forced/closed-loop stepping,
// dead-time insertion and low-side PWM. Phase vectors are indexed [0]=R, [1]=S, [2]=T.
module bldc_commutator #(
  parameter int PWM_W     = 8,
  parameter int PWM_DIV   = 4,
  parameter int FILT_N    = 16,
  parameter int WIN_CYC   = 500000,
  parameter int FORCE_CYC = 250000,
  parameter int DEAD_CYC  = 50,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             direction,
  input  logic [2:0]       hall,
  input  logic [PWM_W-1:0] duty,
  output logic [2:0]       hin,
  output logic [2:0]       lin_n,
  output logic [CNT_W-1:0] edge_count,
  output logic             edge_valid,
  output logic [1:0]       state_o,
  output logic             hall_fault
);

  localparam int FLT_W  = $clog2(FILT_N + 1);
  localparam int WIN_W  = $clog2(WIN_CYC + 1);
  localparam int FRC_W  = $clog2(FORCE_CYC + 1);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int DIV_W  = $clog2(PWM_DIV + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FORCED = 2'd1, S_CLOSED = 2'd2, S_FAULT = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [1:0]         rst_sync;
  logic               run;
  logic [2:0]         h_s1, h_s2, h_cand, h_acc;
  logic               h_vld, acc_upd, edge_det, hall_bad;
  logic [FLT_W-1:0]   f_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic               win_end;
  logic [CNT_W-1:0]   spd;
  logic [DIV_W-1:0]   pdiv;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               pwm;
  logic [2:0]         step, step_nxt, step_adv;
  logic [FRC_W-1:0]   frc_cnt, frc_nxt;
  logic [DEAD_W-1:0]  dead_cnt, dead_nxt;
  logic [2:0]         hi_sel, lo_sel;
  logic               drive;

  // Reset release is retimed; until run rises the controller is held in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign acc_upd  = (h_s2 == h_cand) && (f_cnt == FLT_W'(FILT_N - 1));
  assign edge_det = acc_upd && h_vld && (h_cand != h_acc);
  assign hall_bad = h_vld && ((h_acc == 3'b000) || (h_acc == 3'b111));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_s1 <= '0; h_s2 <= '0; h_cand <= '0; h_acc <= '0; h_vld <= 1'b0; f_cnt <= '0;
    end else begin
      h_s1 <= hall;
      h_s2 <= h_s1;
      if (h_s2 != h_cand) begin
        h_cand <= h_s2;
        f_cnt  <= FLT_W'(1);
      end else if (f_cnt != FLT_W'(FILT_N)) begin
        f_cnt <= f_cnt + 1'b1;
      end
      if (acc_upd) begin
        h_acc <= h_cand;
        h_vld <= 1'b1;
      end
    end
  end

  assign win_end = (win_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= WIN_W'(WIN_CYC - 1); spd <= '0; edge_count <= '0; edge_valid <= 1'b0;
    end else if (run) begin
      if (win_end) begin
        win_cnt    <= WIN_W'(WIN_CYC - 1);
        edge_count <= spd;
        edge_valid <= 1'b1;
        spd        <= edge_det ? CNT_W'(1) : '0;
      end else begin
        win_cnt    <= win_cnt - 1'b1;
        edge_valid <= 1'b0;
        if (edge_det && (spd != '1)) spd <= spd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdiv <= '0; pwm_cnt <= '0;
    end else if (pdiv == '0) begin
      pdiv    <= DIV_W'(PWM_DIV - 1);
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      pdiv <= pdiv - 1'b1;
    end
  end
  assign pwm = (pwm_cnt < duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; hall_fault <= 1'b0;
    end else begin
      state <= state_nxt; hall_fault <= (state_nxt == S_FAULT);
    end
  end

  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (enable) state_nxt = hall_bad ? S_FAULT : S_FORCED;
        S_FORCED: if (!enable) state_nxt = S_IDLE;
                  else if (hall_bad) state_nxt = S_FAULT;
                  else if (win_end && (spd >= CNT_W'(2))) state_nxt = S_CLOSED;
        S_CLOSED: if (!enable) state_nxt = S_IDLE;
                  else if (hall_bad) state_nxt = S_FAULT;
                  else if (win_end && (spd == '0)) state_nxt = S_FORCED;
        default:  if (!enable) state_nxt = S_IDLE;
      endcase
    end
  end

  function automatic logic [2:0] hall_to_step(input logic [2:0] h, input logic cw, input logic [2:0] cur);
    case (h)
      3'd1:    return cw ? 3'd4 : 3'd1;
      3'd2:    return cw ? 3'd0 : 3'd3;
      3'd3:    return cw ? 3'd5 : 3'd2;
      3'd4:    return cw ? 3'd2 : 3'd5;
      3'd5:    return cw ? 3'd3 : 3'd0;
      3'd6:    return cw ? 3'd1 : 3'd4;
      default: return cur;
    endcase
  endfunction

  assign step_adv = direction ? ((step == 3'd5) ? 3'd0 : step + 3'd1)
                              : ((step == 3'd0) ? 3'd5 : step - 3'd1);

  // Any change of commanded step (re)arms the dead timer.
  always_comb begin
    step_nxt = step;
    frc_nxt  = frc_cnt;
    if (state_nxt == S_FORCED) begin
      if (state != S_FORCED) begin
        frc_nxt = FRC_W'(FORCE_CYC - 1);
      end else if (frc_cnt == '0) begin
        step_nxt = step_adv;
        frc_nxt  = FRC_W'(FORCE_CYC - 1);
      end else begin
        frc_nxt = frc_cnt - 1'b1;
      end
    end else if (state_nxt == S_CLOSED) begin
      step_nxt = hall_to_step(h_acc, direction, step);
    end
    dead_nxt = dead_cnt;
    if (step_nxt != step)     dead_nxt = DEAD_W'(DEAD_CYC);
    else if (dead_cnt != '0)  dead_nxt = dead_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0; frc_cnt <= '0; dead_cnt <= '0;
    end else begin
      step <= step_nxt; frc_cnt <= frc_nxt; dead_cnt <= dead_nxt;
    end
  end

  always_comb begin
    hi_sel = 3'b000;
    lo_sel = 3'b000;
    case (step)
      3'd0:    begin hi_sel = 3'b001; lo_sel = 3'b010; end
      3'd1:    begin hi_sel = 3'b001; lo_sel = 3'b100; end
      3'd2:    begin hi_sel = 3'b010; lo_sel = 3'b100; end
      3'd3:    begin hi_sel = 3'b010; lo_sel = 3'b001; end
      3'd4:    begin hi_sel = 3'b100; lo_sel = 3'b001; end
      3'd5:    begin hi_sel = 3'b100; lo_sel = 3'b010; end
      default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
    endcase
    drive = run && enable && ((state == S_FORCED) || (state == S_CLOSED)) && (dead_cnt == '0);
    hin   = drive ? hi_sel : 3'b000;
    lin_n = drive ? ~(lo_sel & {3{pwm}}) : 3'b111;
  end

  assign state_o = state;

endmodule

// File: tb/tb_bldc_commutator.sv
// Scenario bench for bldc_commutator with shortened timing parameters and a
// rotation-position reference model of the commutation tables.
module tb_bldc_commutator;
  localparam int PWM_W = 8, PWM_DIV = 2, FILT_N = 16, WIN_CYC = 4000;
  localparam int FORCE_CYC = 600, DEAD_CYC = 50, CNT_W = 12;
  localparam int PER = (1 << PWM_W) * PWM_DIV;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, direction = 1'b1;
  logic [2:0] hall = 3'd5;
  logic [PWM_W-1:0] duty = '0;
  logic [2:0] hin, lin_n;
  logic [CNT_W-1:0] edge_count;
  logic edge_valid, hall_fault;
  logic [1:0] state_o;

  int total = 0, bad = 0, cyc = 0, hidx = 0;
  int cw_seq [6] = '{1, 3, 2, 6, 4, 5};

  bldc_commutator #(.PWM_W(PWM_W), .PWM_DIV(PWM_DIV), .FILT_N(FILT_N), .WIN_CYC(WIN_CYC),
                    .FORCE_CYC(FORCE_CYC), .DEAD_CYC(DEAD_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction), .hall(hall), .duty(duty),
    .hin(hin), .lin_n(lin_n), .edge_count(edge_count), .edge_valid(edge_valid),
    .state_o(state_o), .hall_fault(hall_fault));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hall codes walk cw_seq in rotor order; CW step leads position by 4, CCW by 1.
  function automatic int ref_step(input logic [2:0] h, input logic dir);
    int i;
    i = 0;
    for (int k = 0; k < 6; k++) if (cw_seq[k] == int'(h)) i = k;
    return dir ? (i + 4) % 6 : (i + 1) % 6;
  endfunction
  function automatic logic [2:0] hi_mask(input int s);
    return 3'(1 << (s / 2));
  endfunction
  function automatic int lo_leg(input int s);
    return (s / 2 + 1 + s % 2) % 3;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic find_gap(input int limit, output int len, output int lin_bad);
    len = 0; lin_bad = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (hin === 3'b000) begin len = 1; break; end
    end
    if (len == 1) begin
      if (lin_n !== 3'b111) lin_bad++;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (hin !== 3'b000) break;
        len++;
        if (lin_n !== 3'b111) lin_bad++;
      end
    end
  endtask

  task automatic measure_drive(output logic [2:0] h0, output int hchg, output int l0, output int l1, output int l2);
    hchg = 0; l0 = 0; l1 = 0; l2 = 0; h0 = 3'b000;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == 0) h0 = hin;
      if (hin !== h0) hchg++;
      if (lin_n[0] === 1'b0) l0++;
      if (lin_n[1] === 1'b0) l1++;
      if (lin_n[2] === 1'b0) l2++;
    end
  endtask

  task automatic wait_strobe(input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (edge_valid === 1'b1) begin found = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; direction = 1'b1; hall = 3'b101; duty = 8'd128;
    tick(5);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
    total++; if (hin !== 3'b000) begin bad++; $display("FAIL rst_hin: got %b want 000", hin); end
    total++; if (lin_n !== 3'b111) begin bad++; $display("FAIL rst_lin: got %b want 111", lin_n); end
    total++; if (edge_count !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", edge_count); end
    total++; if (edge_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", edge_valid); end
    total++; if (hall_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", hall_fault); end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({hin, lin_n, state_o} !== {3'b000, 3'b111, 2'd0}) begin
        bad++; $display("FAIL idle_hold cyc %0d: got hin=%b lin=%b st=%0d want 000/111/0", i, hin, lin_n, state_o);
      end
    end
  endtask

  task automatic test_closed_cw;
    bit reached;
    int len, lb, l0, l1, l2, hchg, exp_s;
    int lc [3];
    logic [2:0] h0;
    enable = 1'b1; direction = 1'b1; duty = 8'd128; hidx = 0; hall = 3'(cw_seq[0]);
    reached = 0;
    for (int k = 0; k < 16 && !reached; k++) begin
      tick(1000);
      if (state_o === 2'd2) reached = 1;
      else begin hidx = (hidx + 1) % 6; hall = 3'(cw_seq[hidx]); end
    end
    total++; if (reached !== 1'b1) begin bad++; $display("FAIL closed_reach: got state %0d want 2", state_o); end
    tick(200);
    for (int k = 0; k < 6; k++) begin
      hidx = (hidx + 1) % 6; hall = 3'(cw_seq[hidx]);
      exp_s = ref_step(hall, 1'b1);
      find_gap(200, len, lb);
      total++; if (len != DEAD_CYC) begin bad++; $display("FAIL cw_gap h=%0d: got %0d want %0d", hall, len, DEAD_CYC); end
      total++; if (lb != 0) begin bad++; $display("FAIL cw_gap_low h=%0d: got %0d want 0", hall, lb); end
      measure_drive(h0, hchg, l0, l1, l2);
      lc[0] = l0; lc[1] = l1; lc[2] = l2;
      total++; if (h0 !== hi_mask(exp_s) || hchg != 0) begin
        bad++; $display("FAIL cw_hin step %0d: got %b chg %0d want %b", exp_s, h0, hchg, hi_mask(exp_s));
      end
      total++; if (lc[lo_leg(exp_s)] != 128 * PWM_DIV || l0 + l1 + l2 != 128 * PWM_DIV) begin
        bad++; $display("FAIL cw_pwm step %0d: got %0d/%0d/%0d want %0d on leg %0d", exp_s, l0, l1, l2, 128 * PWM_DIV, lo_leg(exp_s));
      end
      tick(300);
    end
  endtask

  task automatic test_random_closed;
    int len, lb, l0, l1, l2, hchg, exp_s;
    int lc [3];
    logic [2:0] h0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0 || $urandom_range(0, 1) == 0) begin
        hidx = (hidx + int'($urandom_range(1, 5))) % 6; hall = 3'(cw_seq[hidx]);
      end else begin
        direction = ~direction;
      end
      exp_s = ref_step(hall, direction);
      find_gap(200, len, lb);
      total++; if (len != DEAD_CYC || lb != 0) begin
        bad++; $display("FAIL rnd_gap it %0d: got len %0d lowbad %0d want %0d/0", k, len, lb, DEAD_CYC);
      end
      measure_drive(h0, hchg, l0, l1, l2);
      lc[0] = l0; lc[1] = l1; lc[2] = l2;
      total++; if (h0 !== hi_mask(exp_s) || hchg != 0 || lc[lo_leg(exp_s)] != int'(duty) * PWM_DIV ||
                   l0 + l1 + l2 != int'(duty) * PWM_DIV) begin
        bad++; $display("FAIL rnd_drive it %0d h=%0d dir=%0d: got hin %b lows %0d/%0d/%0d want step %0d", k, hall, direction, h0, l0, l1, l2, exp_s);
      end
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL rnd_state it %0d: got %0d want 2", k, state_o); end
    end
    if (direction !== 1'b1) begin direction = 1'b1; end
    tick(300);
  endtask

  task automatic test_glitch;
    bit found;
    int chg, len, lb;
    logic [2:0] hi0, h0;
    wait_strobe(2 * WIN_CYC, found);
    total++; if (!found) begin bad++; $display("FAIL glitch_strobe: got none want strobe"); end
    tick(100);
    hi0 = hin; h0 = hall;
    hall = 3'(cw_seq[(hidx + 1) % 6]);
    tick(FILT_N - 1);
    hall = h0;
    chg = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (hin !== hi0) chg++; end
    total++; if (chg != 0) begin bad++; $display("FAIL glitch_short: got %0d changed cycles want 0", chg); end
    hidx = (hidx + 1) % 6; hall = 3'(cw_seq[hidx]);
    find_gap(200, len, lb);
    total++; if (len != DEAD_CYC) begin bad++; $display("FAIL glitch_long_gap: got %0d want %0d", len, DEAD_CYC); end
    wait_strobe(WIN_CYC + 10, found);
    total++; if (!found || edge_count !== CNT_W'(1)) begin
      bad++; $display("FAIL glitch_count: got %0d (strobe %0d) want 1", edge_count, found);
    end
  endtask

  task automatic test_stall;
    bit found;
    int len, lb, l0, l1, l2, hchg, t1, t2, s1, s2, hi_i, lo_i;
    logic [2:0] h0;
    wait_strobe(WIN_CYC + 10, found);
    total++; if (!found || edge_count !== '0) begin bad++; $display("FAIL stall_count: got %0d want 0", edge_count); end
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL stall_state: got %0d want 1", state_o); end
    find_gap(FORCE_CYC + 100, len, lb);
    t1 = cyc - len;
    measure_drive(h0, hchg, l0, l1, l2);
    hi_i = (h0 == 3'b010) ? 1 : (h0 == 3'b100) ? 2 : 0;
    lo_i = (l1 > 0) ? 1 : (l2 > 0) ? 2 : 0;
    s1 = 2 * hi_i + ((lo_i == (hi_i + 1) % 3) ? 0 : 1);
    find_gap(FORCE_CYC + 100, len, lb);
    t2 = cyc - len;
    total++; if (len != DEAD_CYC) begin bad++; $display("FAIL forced_gap: got %0d want %0d", len, DEAD_CYC); end
    total++; if (t2 - t1 != FORCE_CYC) begin bad++; $display("FAIL forced_period: got %0d want %0d", t2 - t1, FORCE_CYC); end
    measure_drive(h0, hchg, l0, l1, l2);
    hi_i = (h0 == 3'b010) ? 1 : (h0 == 3'b100) ? 2 : 0;
    lo_i = (l1 > 0) ? 1 : (l2 > 0) ? 2 : 0;
    s2 = 2 * hi_i + ((lo_i == (hi_i + 1) % 3) ? 0 : 1);
    total++; if (s2 != (s1 + 1) % 6) begin bad++; $display("FAIL forced_advance: got %0d after %0d want %0d", s2, s1, (s1 + 1) % 6); end
  endtask

  task automatic test_fault;
    int errs;
    hall = 3'b111;
    tick(FILT_N + 10);
    total++; if (hall_fault !== 1'b1) begin bad++; $display("FAIL fault_flag: got %b want 1", hall_fault); end
    total++; if (state_o !== 2'd3) begin bad++; $display("FAIL fault_state: got %0d want 3", state_o); end
    total++; if (hin !== 3'b000 || lin_n !== 3'b111) begin bad++; $display("FAIL fault_off: got %b/%b want 000/111", hin, lin_n); end
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hall_fault !== 1'b1 || state_o !== 2'd3 || hin !== 3'b000 || lin_n !== 3'b111) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL fault_persist: got %0d bad cycles want 0", errs); end
    enable = 1'b0;
    tick(1);
    total++; if (hall_fault !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("FAIL fault_clear: got flag %b state %0d want 0/0", hall_fault, state_o);
    end
    hall = 3'd1; hidx = 0;
    tick(40);
  endtask

  task automatic test_duty;
    bit found;
    int len, lb, l0, l1, l2, hchg, d;
    logic [2:0] h0;
    wait_strobe(WIN_CYC + 10, found);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? 0 : (k == 1) ? 255 : int'($urandom_range(1, 254));
      duty = PWM_W'(d);
      find_gap(FORCE_CYC + 100, len, lb);
      measure_drive(h0, hchg, l0, l1, l2);
      total++; if (l0 + l1 + l2 != d * PWM_DIV || hchg != 0 || h0 === 3'b000) begin
        bad++; $display("FAIL duty_%0d: got low cycles %0d hin %b chg %0d want %0d", d, l0 + l1 + l2, h0, hchg, d * PWM_DIV);
      end
    end
  endtask

  task automatic test_async_reset;
    bit found;
    duty = 8'd128;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin @(negedge clk); if (hin !== 3'b000) found = 1; end
    enable = 1'b0;
    #1;
    total++; if (hin !== 3'b000 || lin_n !== 3'b111) begin bad++; $display("FAIL enable_off: got %b/%b want 000/111", hin, lin_n); end
    @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL enable_idle: got %0d want 0", state_o); end
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin @(negedge clk); if (hin !== 3'b000) found = 1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (hin !== 3'b000 || lin_n !== 3'b111 || state_o !== 2'd0) begin
      bad++; $display("FAIL async_rst: got %b/%b st %0d want 000/111/0", hin, lin_n, state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (state_o !== 2'd0 || hin !== 3'b000) begin bad++; $display("FAIL rst_release: got st %0d hin %b want 0/000", state_o, hin); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); if (state_o === 2'd1) found = 1; end
    total++; if (!found) begin bad++; $display("FAIL rst_restart: got state %0d want 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_closed_cw();
    test_random_closed();
    test_glitch();
    test_stall();
    test_fault();
    test_duty();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
